// File: rtl/spi_target_pkg.sv
// Shared types and constants for the DFB board SPI target: FSM state encoding,
// frame geometry and the default byte sent when nothing is queued.
package dfb_spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_e;

  localparam int          SPI_BITS          = 8;
  localparam int          CNT_W             = 4;
  localparam logic [CNT_W-1:0] LAST_BIT     = 4'd7;
  localparam logic [7:0]  DEFAULT_IDLE_BYTE = 8'hFF;

endpackage

// File: rtl/spi_target_if.sv
// CLKOSC-domain byte handshake between the SPI target and its user logic.
// TX: TX_LOAD writes TX_DATA only while TX_READY=1. RX: RX_VALID holds until RX_ACK.
interface spi_target_if;
  import dfb_spi_pkg::*;

  logic [7:0] TX_DATA;
  logic       TX_LOAD;
  logic       TX_READY;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic       RX_ACK;
  logic       RX_OVERRUN;
  logic       FRAME_ERR;
  logic       BUSY;
  state_e     state_dbg;

  modport master (
    output TX_DATA, TX_LOAD, RX_ACK,
    input  TX_READY, RX_DATA, RX_VALID, RX_OVERRUN, FRAME_ERR, BUSY, state_dbg
  );

  modport slave (
    input  TX_DATA, TX_LOAD, RX_ACK,
    output TX_READY, RX_DATA, RX_VALID, RX_OVERRUN, FRAME_ERR, BUSY, state_dbg
  );

endinterface

// File: rtl/spi_target_pin_sync.sv
// Pin synchroniser with registered edge detect; level_o is delayed to line up
// with rise_o/fall_o so consumers see a consistent snapshot.
module spi_pin_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;
  logic              fall_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin_i};
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[STAGES-1] & prev_q;
    end
  end

  assign level_o = prev_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target, MSB first, 8-bit frames, pins oversampled on CLKOSC.
// Define SPI_TARGET_ECHO_EN to echo the last received byte when no TX byte is queued.
module spi_target
  import dfb_spi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = DEFAULT_IDLE_BYTE
) (
  input  logic CLKOSC,
  input  logic RST,
  input  logic SPI_CS_N,
  input  logic SPI_SCK,
  input  logic SPI_MOSI,
  output logic SPI_MISO,
  output logic SPI_MISO_OE,
  spi_target_if.slave hs
);

  logic cs_n_s, cs_rise, cs_fall;
  logic sck_s, sck_rise, sck_fall;
  logic unused_sck;
  logic [SYNC_STAGES:0] mosi_q;
  logic mosi_s;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bitcnt_q;
  logic [7:0]       shift_rx_q;
  logic [7:0]       shift_tx_q;
  logic             miso_q;
  logic [7:0]       hold_q;
  logic             hold_full_q;
  logic [7:0]       rx_data_q;
  logic             rx_valid_q;
  logic             rx_ovr_q;
  logic             frame_err_q;

  logic       in_shift, bit_rise, byte_done, reload;
  logic [7:0] rx_byte, idle_src, tx_src;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk_i(CLKOSC), .rst_i(RST), .pin_i(SPI_CS_N),
    .level_o(cs_n_s), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clk_i(CLKOSC), .rst_i(RST), .pin_i(SPI_SCK),
    .level_o(sck_s), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  assign unused_sck = sck_s;

  // One extra flop so MOSI has the same latency as the registered SCK edge.
  always_ff @(posedge CLKOSC or posedge RST) begin
    if (RST) mosi_q <= '0;
    else     mosi_q <= {mosi_q[SYNC_STAGES-1:0], SPI_MOSI};
  end
  assign mosi_s = mosi_q[SYNC_STAGES];

  assign in_shift  = (state_q == SHIFT);
  assign bit_rise  = in_shift & sck_rise & ~cs_rise;
  assign rx_byte   = {shift_rx_q[6:0], mosi_s};
  assign byte_done = bit_rise & (bitcnt_q == LAST_BIT);
  assign reload    = (state_q == LOAD) | byte_done;

`ifdef SPI_TARGET_ECHO_EN
  // At a byte boundary the byte just assembled is the "last complete" one.
  assign idle_src = byte_done ? rx_byte : rx_data_q;
`else
  assign idle_src = IDLE_BYTE;
`endif
  assign tx_src = hold_full_q ? hold_q : idle_src;

  always_ff @(posedge CLKOSC or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = LOAD;
      LOAD:    state_d = cs_rise ? IDLE : SHIFT;
      SHIFT:   if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    SPI_MISO_OE = 1'b0;
    SPI_MISO    = 1'b1;
    case (state_q)
      LOAD: begin
        SPI_MISO_OE = 1'b1;
        SPI_MISO    = tx_src[7];
      end
      SHIFT: begin
        SPI_MISO_OE = 1'b1;
        SPI_MISO    = miso_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLKOSC or posedge RST) begin
    if (RST) begin
      bitcnt_q    <= '0;
      shift_rx_q  <= '0;
      shift_tx_q  <= '0;
      miso_q      <= 1'b1;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_ovr_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= in_shift & cs_rise & (bitcnt_q != '0);

      if (!in_shift || cs_rise || byte_done) bitcnt_q <= '0;
      else if (bit_rise)                     bitcnt_q <= bitcnt_q + 4'd1;

      if (bit_rise) shift_rx_q <= rx_byte;

      // Bit 7 goes out at reload; falls after bits 1..7 present the rest.
      if (reload) begin
        shift_tx_q <= tx_src;
        miso_q     <= tx_src[7];
      end else if (in_shift && sck_fall && bitcnt_q != '0) begin
        shift_tx_q <= {shift_tx_q[6:0], 1'b0};
        miso_q     <= shift_tx_q[6];
      end

      if (reload && hold_full_q) begin
        hold_full_q <= 1'b0;
      end else if (hs.TX_LOAD && !hold_full_q) begin
        hold_q      <= hs.TX_DATA;
        hold_full_q <= 1'b1;
      end

      if (byte_done) begin
        rx_data_q  <= rx_byte;
        rx_valid_q <= 1'b1;
        rx_ovr_q   <= ~hs.RX_ACK & (rx_ovr_q | rx_valid_q);
      end else if (hs.RX_ACK) begin
        rx_valid_q <= 1'b0;
        rx_ovr_q   <= 1'b0;
      end
    end
  end

  assign hs.TX_READY   = ~hold_full_q;
  assign hs.RX_DATA    = rx_data_q;
  assign hs.RX_VALID   = rx_valid_q;
  assign hs.RX_OVERRUN = rx_ovr_q;
  assign hs.FRAME_ERR  = frame_err_q;
  assign hs.BUSY       = ~cs_n_s;
  assign hs.state_dbg  = state_q;

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: bit-bangs an SPI master, checks RX/TX bytes,
// handshake flags, frame abort and reset mid-frame against hand-computed values.
module tb_spi_target;
  import dfb_spi_pkg::*;

`ifdef SPI_TARGET_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  logic CLKOSC = 1'b0;
  logic RST;
  logic SPI_CS_N, SPI_SCK, SPI_MOSI;
  logic SPI_MISO, SPI_MISO_OE;

  int n_checks  = 0;
  int n_pass    = 0;
  int fe_cycles = 0;
  int fe0;
  logic [7:0] got;

  spi_target_if hs();

  spi_target #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
    .CLKOSC(CLKOSC), .RST(RST),
    .SPI_CS_N(SPI_CS_N), .SPI_SCK(SPI_SCK), .SPI_MOSI(SPI_MOSI),
    .SPI_MISO(SPI_MISO), .SPI_MISO_OE(SPI_MISO_OE),
    .hs(hs)
  );

  always #5 CLKOSC = ~CLKOSC;

  always @(posedge CLKOSC) if (hs.FRAME_ERR === 1'b1) fe_cycles++;

  initial begin
    #1ms;
    $display("FAIL timeout: run did not complete, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLKOSC);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] miso_b);
    miso_b = 8'h00;
    for (int i = 0; i < n; i++) begin
      SPI_MOSI = b[7-i];
      wait_cyc(6);
      miso_b[7-i] = SPI_MISO;
      SPI_SCK = 1'b1;
      wait_cyc(6);
      SPI_SCK = 1'b0;
    end
  endtask

  task automatic cs_low();
    SPI_CS_N = 1'b0;
    wait_cyc(6);
  endtask

  task automatic cs_high();
    wait_cyc(6);
    SPI_CS_N = 1'b1;
    wait_cyc(8);
  endtask

  task automatic rx_ack();
    hs.RX_ACK = 1'b1;
    wait_cyc(1);
    hs.RX_ACK = 1'b0;
    wait_cyc(1);
  endtask

  task automatic tx_load(input logic [7:0] d);
    hs.TX_DATA = d;
    hs.TX_LOAD = 1'b1;
    wait_cyc(1);
    hs.TX_LOAD = 1'b0;
    wait_cyc(1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_miso"},     32'(SPI_MISO),      32'd1);
    check({pfx, "_oe"},       32'(SPI_MISO_OE),   32'd0);
    check({pfx, "_tx_ready"}, 32'(hs.TX_READY),   32'd1);
    check({pfx, "_rx_data"},  32'(hs.RX_DATA),    32'h00);
    check({pfx, "_rx_valid"}, 32'(hs.RX_VALID),   32'd0);
    check({pfx, "_overrun"},  32'(hs.RX_OVERRUN), 32'd0);
    check({pfx, "_frame_err"},32'(hs.FRAME_ERR),  32'd0);
    check({pfx, "_busy"},     32'(hs.BUSY),       32'd0);
    check({pfx, "_state"},    32'(hs.state_dbg),  32'(IDLE));
  endtask

  initial begin
    RST = 1'b1;
    SPI_CS_N = 1'b1; SPI_SCK = 1'b0; SPI_MOSI = 1'b0;
    hs.TX_DATA = 8'h00; hs.TX_LOAD = 1'b0; hs.RX_ACK = 1'b0;
    wait_cyc(3);
    check_reset_outputs("reset");
    RST = 1'b0;
    wait_cyc(4);

    // Plain receive with nothing queued
    cs_low();
    check("busy_in_frame", 32'(hs.BUSY), 32'd1);
    check("oe_in_frame", 32'(SPI_MISO_OE), 32'd1);
    spi_bits(8'hA5, 8, got);
    cs_high();
    check("rx_a5_data", 32'(hs.RX_DATA), 32'hA5);
    check("rx_a5_valid", 32'(hs.RX_VALID), 32'd1);
    check("rx_a5_no_frame_err", 32'(fe_cycles), 32'd0);
    check("rx_a5_idle_miso", 32'(got), ECHO ? 32'h00 : 32'hFF);
    check("busy_after_frame", 32'(hs.BUSY), 32'd0);
    check("oe_after_frame", 32'(SPI_MISO_OE), 32'd0);
    rx_ack();
    check("rx_a5_ack_clears", 32'(hs.RX_VALID), 32'd0);

    // Queued transmit byte
    tx_load(8'h3C);
    check("tx_ready_full", 32'(hs.TX_READY), 32'd0);
    cs_low();
    check("tx_ready_after_load", 32'(hs.TX_READY), 32'd1);
    spi_bits(8'h00, 8, got);
    cs_high();
    check("tx_3c_miso", 32'(got), 32'h3C);
    rx_ack();

    // Multi-byte with underrun; second load while full must be ignored
    tx_load(8'h81);
    tx_load(8'h99);
    check("tx_ready_still_full", 32'(hs.TX_READY), 32'd0);
    cs_low();
    spi_bits(8'h12, 8, got);
    check("multi_b0_miso", 32'(got), 32'h81);
    spi_bits(8'h34, 8, got);
    check("multi_b1_miso", 32'(got), ECHO ? 32'h12 : 32'hFF);
    spi_bits(8'h56, 8, got);
    check("multi_b2_miso", 32'(got), ECHO ? 32'h34 : 32'hFF);
    cs_high();
    check("multi_rx_data", 32'(hs.RX_DATA), 32'h56);
    check("multi_overrun", 32'(hs.RX_OVERRUN), 32'd1);
    rx_ack();
    check("multi_ack_valid", 32'(hs.RX_VALID), 32'd0);
    check("multi_ack_overrun", 32'(hs.RX_OVERRUN), 32'd0);

    // Overrun across two frames
    cs_low(); spi_bits(8'h11, 8, got); cs_high();
    check("ovr_first_valid", 32'(hs.RX_VALID), 32'd1);
    check("ovr_first_no_ovr", 32'(hs.RX_OVERRUN), 32'd0);
    cs_low(); spi_bits(8'h22, 8, got); cs_high();
    check("ovr_second_data", 32'(hs.RX_DATA), 32'h22);
    check("ovr_second_ovr", 32'(hs.RX_OVERRUN), 32'd1);
    rx_ack();
    check("ovr_ack_valid", 32'(hs.RX_VALID), 32'd0);
    check("ovr_ack_ovr", 32'(hs.RX_OVERRUN), 32'd0);

    // Abort after 5 bits with a byte still pending
    cs_low(); spi_bits(8'h77, 8, got); cs_high();
    fe0 = fe_cycles;
    cs_low();
    spi_bits(8'hF0, 5, got);
    cs_high();
    check("abort_frame_err_1cyc", 32'(fe_cycles - fe0), 32'd1);
    check("abort_valid_kept", 32'(hs.RX_VALID), 32'd1);
    check("abort_data_kept", 32'(hs.RX_DATA), 32'h77);
    check("abort_no_overrun", 32'(hs.RX_OVERRUN), 32'd0);
    rx_ack();
    cs_low(); spi_bits(8'h5A, 8, got); cs_high();
    check("after_abort_data", 32'(hs.RX_DATA), 32'h5A);
    check("after_abort_valid", 32'(hs.RX_VALID), 32'd1);
    check("after_abort_no_err", 32'(fe_cycles - fe0), 32'd1);

    // Reset in the middle of a frame with a byte queued and RX_VALID set
    cs_low();
    tx_load(8'hAA);
    spi_bits(8'hE0, 3, got);
    RST = 1'b1;
    #1;
    check_reset_outputs("midrst");
    wait_cyc(2);
    SPI_CS_N = 1'b1;
    SPI_SCK  = 1'b0;
    wait_cyc(4);
    RST = 1'b0;
    wait_cyc(4);
    check("post_rst_state", 32'(hs.state_dbg), 32'(IDLE));
    cs_low(); spi_bits(8'hC3, 8, got); cs_high();
    check("post_rst_rx", 32'(hs.RX_DATA), 32'hC3);
    check("post_rst_valid", 32'(hs.RX_VALID), 32'd1);
    check("post_rst_miso", 32'(got), ECHO ? 32'h00 : 32'hFF);
    rx_ack();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
